cpu_run_ctrl: RTL and testbench

//  Run controller for the 5-stage pipeline CPU; self-contained, reusable replacement for hard-coded test-bench timing.

---
 rtl/cpu_run_ctrl.sv | 157 +++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run controller for the 5-stage pipeline CPU.
// It holds the core in reset, latches the forwarding mode for the run,
// counts cycles, retired instructions and bubbles, and ends the run on
// the instruction target, on a halt request or on a cycle timeout.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | after reset; core held in reset, waiting for start
// RST_HOLD | core_reset held for RST_CYCLES cycles before the run begins
// RUN      | core running; counting; watching target, halt and limit
// DRAIN    | PIPE_DEPTH cycles for in-flight instructions to retire
// DONE     | core held in reset; counters frozen; start begins a new run
module cpu_run_ctrl #(
  parameter int MAX_INSTR    = 1024,
  parameter int PIPE_DEPTH   = 5,
  parameter int RST_CYCLES   = 2,
  parameter int CYC_MARGIN   = 64,
  parameter int CNT_W        = 32,
  parameter bit FORW_DEFAULT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             forw_mode_in,
  input  logic             retire_valid,
  input  logic             halt_req,
  output logic             core_reset,
  output logic             isForw_ON,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count,
  output logic [CNT_W-1:0] bubble_count
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RST_HOLD = 3'd1,
    S_RUN      = 3'd2,
    S_DRAIN    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam int HOLD_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int DRAIN_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_INIT  = HOLD_W'(RST_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(PIPE_DEPTH - 1);
  localparam logic [CNT_W-1:0]   TARGET     = CNT_W'(MAX_INSTR);
  localparam logic [CNT_W-1:0]   LIMIT      = CNT_W'(MAX_INSTR + PIPE_DEPTH + CYC_MARGIN);

  state_t               state_q, state_d;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic                 clear_run;
  logic                 count_en;
  logic                 timeout_set;
  logic [CNT_W-1:0]     cyc_nxt, ret_nxt, bub_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Candidate counter values for this cycle; the target and limit checks
  // look at these so that the current cycle's strobe is included.
  always_comb begin
    cyc_nxt = sat_inc(cycle_count);
    ret_nxt = retire_valid ? sat_inc(retire_count) : retire_count;
    bub_nxt = retire_valid ? bubble_count : sat_inc(bubble_count);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode; completion (target/halt) takes priority over the limit.
  always_comb begin
    state_d     = state_q;
    clear_run   = 1'b0;
    count_en    = 1'b0;
    timeout_set = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RST_HOLD;
          clear_run = 1'b1;
        end
      end
      S_RST_HOLD: begin
        if (hold_cnt == '0) state_d = S_RUN;
      end
      S_RUN: begin
        count_en = 1'b1;
        if ((ret_nxt >= TARGET) || halt_req) begin
          state_d = S_DRAIN;
        end else if (cyc_nxt >= LIMIT) begin
          state_d     = S_DONE;
          timeout_set = 1'b1;
        end
      end
      S_DRAIN: begin
        count_en = 1'b1;
        if (drain_cnt == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Down-counting timers, reloaded whenever their state is not active.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt  <= HOLD_INIT;
      drain_cnt <= DRAIN_INIT;
    end else begin
      hold_cnt  <= (state_q == S_RST_HOLD && hold_cnt != '0)  ? hold_cnt - 1'b1  : HOLD_INIT;
      drain_cnt <= (state_q == S_DRAIN    && drain_cnt != '0) ? drain_cnt - 1'b1 : DRAIN_INIT;
    end
  end

  // Registered outputs, decoded from the state being entered on this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_reset <= 1'b1;
      running    <= 1'b0;
      done       <= 1'b0;
    end else begin
      core_reset <= (state_d == S_IDLE) || (state_d == S_RST_HOLD) || (state_d == S_DONE);
      running    <= (state_d == S_RUN) || (state_d == S_DRAIN);
      done       <= (state_d == S_DONE);
    end
  end

  // Run statistics, forwarding mode and timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      isForw_ON    <= FORW_DEFAULT;
      timeout      <= 1'b0;
      cycle_count  <= '0;
      retire_count <= '0;
      bubble_count <= '0;
    end else if (clear_run) begin
      isForw_ON    <= forw_mode_in;
      timeout      <= 1'b0;
      cycle_count  <= '0;
      retire_count <= '0;
      bubble_count <= '0;
    end else if (count_en) begin
      cycle_count  <= cyc_nxt;
      retire_count <= ret_nxt;
      bubble_count <= bub_nxt;
      if (timeout_set) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl: two instances (default parameters and
// MAX_INSTR=8) share stimulus; sel chooses which one a scenario checks.
// Expected results come from a cycle-by-cycle run model over the
// per-cycle retire/halt/start tables.
module tb_cpu_run_ctrl;

  localparam int NCYC = 1500;

  logic clk = 1'b0;
  logic reset, start, forw_mode_in, retire_valid, halt_req;

  logic        a_core_reset, a_forw, a_running, a_done, a_timeout;
  logic [31:0] a_cyc, a_ret, a_bub;
  logic        b_core_reset, b_forw, b_running, b_done, b_timeout;
  logic [31:0] b_cyc, b_ret, b_bub;

  logic        o_core_reset, o_forw, o_running, o_done, o_timeout;
  logic [31:0] o_cyc, o_ret, o_bub;
  logic        sel;

  int n_tests = 0;
  int n_fail  = 0;

  bit rr [NCYC+1];
  bit hh [NCYC+1];
  bit ss [NCYC+1];

  int   e_cyc, e_ret, e_bub;
  logic e_to;

  always #5 clk = ~clk;

  cpu_run_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .forw_mode_in(forw_mode_in),
    .retire_valid(retire_valid), .halt_req(halt_req),
    .core_reset(a_core_reset), .isForw_ON(a_forw), .running(a_running),
    .done(a_done), .timeout(a_timeout),
    .cycle_count(a_cyc), .retire_count(a_ret), .bubble_count(a_bub)
  );

  cpu_run_ctrl #(.MAX_INSTR(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .forw_mode_in(forw_mode_in),
    .retire_valid(retire_valid), .halt_req(halt_req),
    .core_reset(b_core_reset), .isForw_ON(b_forw), .running(b_running),
    .done(b_done), .timeout(b_timeout),
    .cycle_count(b_cyc), .retire_count(b_ret), .bubble_count(b_bub)
  );

  always_comb begin
    o_core_reset = sel ? b_core_reset : a_core_reset;
    o_forw       = sel ? b_forw       : a_forw;
    o_running    = sel ? b_running    : a_running;
    o_done       = sel ? b_done       : a_done;
    o_timeout    = sel ? b_timeout    : a_timeout;
    o_cyc        = sel ? b_cyc        : a_cyc;
    o_ret        = sel ? b_ret        : a_ret;
    o_bub        = sel ? b_bub        : a_bub;
  end

  // Run model: a run lasts until the target/halt plus PIPE_DEPTH drain
  // cycles, or until the cycle limit if neither happened first.
  task automatic model_run(input int max_i);
    int  limit;
    int  drain_left;
    bit  in_drain;
    limit = max_i + 5 + 64;
    drain_left = 0;
    in_drain = 0;
    e_cyc = 0; e_ret = 0; e_bub = 0; e_to = 1'b0;
    for (int k = 1; k <= NCYC; k++) begin
      e_cyc++;
      if (rr[k]) e_ret++; else e_bub++;
      if (in_drain) begin
        drain_left--;
        if (drain_left == 0) return;
      end else if (e_ret >= max_i || hh[k]) begin
        in_drain = 1;
        drain_left = 5;
      end else if (e_cyc >= limit) begin
        e_to = 1'b1;
        return;
      end
    end
  endtask

  task automatic clear_tables();
    for (int k = 0; k <= NCYC; k++) begin
      rr[k] = 0; hh[k] = 0; ss[k] = 0;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Starts a run from IDLE/DONE, replays the tables and checks the result.
  task automatic run_and_check(input string name, input logic forw);
    int k;
    int max_i;
    max_i = sel ? 8 : 1024;
    model_run(max_i);
    @(negedge clk);
    start = 1'b1; forw_mode_in = forw;
    @(negedge clk);
    start = 1'b0; forw_mode_in = ~forw;
    n_tests++;
    if (o_core_reset !== 1'b1 || o_running !== 1'b0 || o_done !== 1'b0 ||
        o_cyc !== 32'd0 || o_ret !== 32'd0 || o_bub !== 32'd0 || o_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start_clear: core_reset=%b running=%b done=%b cyc=%0d ret=%0d bub=%0d to=%b, want 1 0 0 0 0 0 0",
               name, o_core_reset, o_running, o_done, o_cyc, o_ret, o_bub, o_timeout);
    end
    n_tests++;
    if (o_forw !== forw) begin
      n_fail++;
      $display("FAIL %s forw_latch: isForw_ON=%b want %b", name, o_forw, forw);
    end
    @(negedge clk);
    n_tests++;
    if (o_core_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL %s rst_hold2: core_reset=%b want 1", name, o_core_reset);
    end
    @(negedge clk);
    n_tests++;
    if (o_core_reset !== 1'b0 || o_running !== 1'b1) begin
      n_fail++;
      $display("FAIL %s run_entry: core_reset=%b running=%b want 0 1", name, o_core_reset, o_running);
    end
    k = 1;
    retire_valid = rr[1]; halt_req = hh[1]; start = ss[1];
    forever begin
      @(negedge clk);
      if (o_done === 1'b1 || k >= NCYC) break;
      k++;
      retire_valid = rr[k]; halt_req = hh[k]; start = ss[k];
    end
    retire_valid = 1'b0; halt_req = 1'b0; start = 1'b0;
    n_tests++;
    if (o_done !== 1'b1 || k != e_cyc) begin
      n_fail++;
      $display("FAIL %s done_time: done=%b after %0d cycles, want done=1 after %0d", name, o_done, k, e_cyc);
    end
    n_tests++;
    if (o_cyc !== 32'(e_cyc) || o_ret !== 32'(e_ret) || o_bub !== 32'(e_bub) || o_timeout !== e_to) begin
      n_fail++;
      $display("FAIL %s counts: cyc=%0d ret=%0d bub=%0d to=%b, want %0d %0d %0d %b",
               name, o_cyc, o_ret, o_bub, o_timeout, e_cyc, e_ret, e_bub, e_to);
    end
    n_tests++;
    if (o_core_reset !== 1'b1 || o_running !== 1'b0 || o_forw !== forw) begin
      n_fail++;
      $display("FAIL %s done_outs: core_reset=%b running=%b isForw_ON=%b, want 1 0 %b",
               name, o_core_reset, o_running, o_forw, forw);
    end
    // DONE must freeze everything while retire/halt keep toggling.
    retire_valid = 1'b1; halt_req = 1'b1;
    repeat (3) @(negedge clk);
    retire_valid = 1'b0; halt_req = 1'b0;
    n_tests++;
    if (o_done !== 1'b1 || o_cyc !== 32'(e_cyc) || o_ret !== 32'(e_ret) || o_bub !== 32'(e_bub)) begin
      n_fail++;
      $display("FAIL %s done_freeze: done=%b cyc=%0d ret=%0d bub=%0d, want 1 %0d %0d %0d",
               name, o_done, o_cyc, o_ret, o_bub, e_cyc, e_ret, e_bub);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    reset = 1'b1; start = 1'b0; forw_mode_in = 1'b1; retire_valid = 1'b0; halt_req = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (a_core_reset !== 1'b1 || a_forw !== 1'b0 || a_running !== 1'b0 || a_done !== 1'b0 || a_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: core_reset=%b isForw_ON=%b running=%b done=%b to=%b, want 1 0 0 0 0",
               a_core_reset, a_forw, a_running, a_done, a_timeout);
    end
    n_tests++;
    if (a_cyc !== 32'd0 || a_ret !== 32'd0 || a_bub !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_counts: cyc=%0d ret=%0d bub=%0d, want 0", a_cyc, a_ret, a_bub);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (a_core_reset !== 1'b1 || a_running !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: core_reset=%b running=%b, want 1 0", a_core_reset, a_running);
    end
  endtask

  task automatic test_full_run();
    sel = 1'b0;
    clear_tables();
    for (int k = 1; k <= NCYC; k++) rr[k] = 1;
    run_and_check("full_run", 1'b1);
    n_tests++;
    if (a_ret !== 32'd1029 || a_cyc !== 32'd1029 || a_bub !== 32'd0 || a_timeout !== 1'b0 || a_forw !== 1'b1) begin
      n_fail++;
      $display("FAIL full_run_abs: ret=%0d cyc=%0d bub=%0d to=%b forw=%b, want 1029 1029 0 0 1",
               a_ret, a_cyc, a_bub, a_timeout, a_forw);
    end
  endtask

  task automatic test_max8();
    pulse_reset();
    sel = 1'b1;
    clear_tables();
    for (int k = 1; k <= NCYC; k++) rr[k] = (k % 2 == 1);
    run_and_check("max8_alt", 1'b0);
    n_tests++;
    if (b_cyc !== 32'd20 || b_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL max8_abs: cyc=%0d to=%b, want 20 0", b_cyc, b_timeout);
    end
    sel = 1'b0;
  endtask

  task automatic test_timeout();
    pulse_reset();
    sel = 1'b0;
    clear_tables();
    run_and_check("timeout", 1'b0);
    n_tests++;
    if (a_cyc !== 32'd1093 || a_timeout !== 1'b1 || a_ret !== 32'd0 || a_bub !== 32'd1093) begin
      n_fail++;
      $display("FAIL timeout_abs: cyc=%0d to=%b ret=%0d bub=%0d, want 1093 1 0 1093",
               a_cyc, a_timeout, a_ret, a_bub);
    end
  endtask

  task automatic test_halt();
    sel = 1'b0;
    clear_tables();
    for (int k = 1; k <= NCYC; k++) rr[k] = 1;
    hh[10] = 1;
    hh[12] = 1;
    run_and_check("halt10", 1'b1);
    n_tests++;
    if (a_cyc !== 32'd15 || a_timeout !== 1'b0 || a_done !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_abs: cyc=%0d to=%b done=%b, want 15 0 1", a_cyc, a_timeout, a_done);
    end
  endtask

  task automatic test_start_ignored();
    sel = 1'b0;
    clear_tables();
    for (int k = 1; k <= NCYC; k++) begin
      rr[k] = ($urandom_range(3, 0) != 0);
      ss[k] = ($urandom_range(3, 0) == 0);
    end
    hh[$urandom_range(120, 30)] = 1;
    run_and_check("start_ignored", 1'b0);
  endtask

  task automatic test_reset_mid_run();
    int k;
    sel = 1'b0;
    @(negedge clk);
    start = 1'b1; forw_mode_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (a_running !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (a_running !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_enter: running=%b want 1", a_running);
    end
    repeat (30) begin
      retire_valid = $urandom_range(1, 0);
      @(negedge clk);
    end
    retire_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_tests++;
    if (a_core_reset !== 1'b1 || a_running !== 1'b0 || a_done !== 1'b0 || a_forw !== 1'b0 ||
        a_cyc !== 32'd0 || a_ret !== 32'd0 || a_bub !== 32'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: core_reset=%b running=%b done=%b forw=%b cyc=%0d ret=%0d bub=%0d, want 1 0 0 0 0 0 0",
               a_core_reset, a_running, a_done, a_forw, a_cyc, a_ret, a_bub);
    end
    @(negedge clk);
    reset = 1'b0;
    clear_tables();
    for (int j = 1; j <= NCYC; j++) rr[j] = 1;
    hh[40] = 1;
    run_and_check("after_reset", 1'b0);
    clear_tables();
    for (int j = 1; j <= NCYC; j++) rr[j] = 1;
    run_and_check("restart_done", 1'b1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      pulse_reset();
      sel = (r % 2 == 1);
      clear_tables();
      for (int k = 1; k <= NCYC; k++) begin
        rr[k] = ($urandom_range(15, 0) < 13);
        ss[k] = ($urandom_range(7, 0) == 0);
      end
      if ($urandom_range(1, 0) == 1) hh[$urandom_range(60, 3)] = 1;
      run_and_check($sformatf("random%0d", r), 1'($urandom_range(1, 0)));
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_max8();
    test_timeout();
    test_halt();
    test_start_ignored();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
